// File: rtl/slave_spi_word.sv
// SPI slave with configurable word width and SPI mode, full-duplex, pins resynchronised to Clock.
// Optional SLAVE_SPI_MISO_TRISTATE_EN: release MISO (high-Z) while chip select is inactive.
`timescale 1ns/1ps
module slave_spi_word #(
  parameter int WIDTH = 8,
  parameter bit CPOL  = 1'b0,
  parameter bit CPHA  = 1'b0
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             CS,
  input  logic             SCK,
  input  logic             MOSI,
  output logic             MISO,
  input  logic [WIDTH-1:0] DataToSend_i,
  output logic [WIDTH-1:0] DataReceived_o,
  output logic             TransactionDone_o,
  output logic             Busy_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam bit SAMPLE_ON_RISE = (CPOL == CPHA);
  localparam bit LOAD_ON_CS = !CPHA;

  logic [2:0]       cs_pipe;
  logic [2:0]       sck_pipe;
  logic [1:0]       mosi_pipe;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rx_shift;
  logic [WIDTH-1:0] tx_shift;

  // Two flops resynchronise, the third holds the previous value for edge detection.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      cs_pipe   <= 3'b111;
      sck_pipe  <= {3{CPOL}};
      mosi_pipe <= 2'b00;
    end else begin
      cs_pipe   <= {cs_pipe[1:0], CS};
      sck_pipe  <= {sck_pipe[1:0], SCK};
      mosi_pipe <= {mosi_pipe[0], MOSI};
    end
  end

  logic cs_s;
  logic mosi_s;
  logic cs_fall;
  logic sck_rise;
  logic sck_fall;
  logic sample_edge;
  logic shift_edge;

  assign cs_s        = cs_pipe[1];
  assign mosi_s      = mosi_pipe[1];
  assign cs_fall     = ~cs_pipe[1] & cs_pipe[2];
  assign sck_rise    = sck_pipe[1] & ~sck_pipe[2];
  assign sck_fall    = ~sck_pipe[1] & sck_pipe[2];
  assign sample_edge = SAMPLE_ON_RISE ? sck_rise : sck_fall;
  assign shift_edge  = SAMPLE_ON_RISE ? sck_fall : sck_rise;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      count             <= '0;
      rx_shift          <= '0;
      tx_shift          <= '0;
      DataReceived_o    <= '0;
      TransactionDone_o <= 1'b0;
      Busy_o            <= 1'b0;
    end else begin
      TransactionDone_o <= 1'b0;
      Busy_o            <= ~cs_s;
      if (cs_s) begin
        count <= '0;
      end else begin
        if (sample_edge) begin
          rx_shift <= {rx_shift[WIDTH-2:0], mosi_s};
          if (count == LAST) begin
            count             <= '0;
            DataReceived_o    <= {rx_shift[WIDTH-2:0], mosi_s};
            TransactionDone_o <= 1'b1;
          end else begin
            count <= count + 1'b1;
          end
        end
        // Counter at zero marks a word boundary: fetch the next outgoing word.
        if (shift_edge) begin
          if (count == '0) tx_shift <= DataToSend_i;
          else             tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
        end
        if (LOAD_ON_CS && cs_fall) tx_shift <= DataToSend_i;
      end
    end
  end

  // Busy_o tracks synchronised CS and lines up with the CS-fall load, so no stale bit glitches out.
`ifdef SLAVE_SPI_MISO_TRISTATE_EN
  assign MISO = Busy_o ? tx_shift[WIDTH-1] : 1'bz;
`else
  assign MISO = Busy_o ? tx_shift[WIDTH-1] : 1'b0;
`endif

endmodule

// File: tb/tb_slave_spi_word.sv
// Bench for slave_spi_word: an 8-bit mode-0 instance and a 16-bit mode-3 instance driven by a bit-level SPI master.
`timescale 1ns/1ps
module tb_slave_spi_word;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic rst, cs, mosi, sck0, sck1, miso0, miso1;
  logic [7:0]  dts0, data0;
  logic [15:0] dts1, data1;
  logic done0, done1, busy0, busy1;

  int errors = 0;
  int checks = 0;
  logic [31:0] rxq0[$];
  logic [31:0] rxq1[$];
  logic [31:0] last_rx0 = 0;
  logic [31:0] last_rx1 = 0;
  logic idle_miso;

  slave_spi_word #(.WIDTH(8), .CPOL(1'b0), .CPHA(1'b0)) dut0 (
    .Clock(clk), .Reset(rst), .CS(cs), .SCK(sck0), .MOSI(mosi), .MISO(miso0),
    .DataToSend_i(dts0), .DataReceived_o(data0),
    .TransactionDone_o(done0), .Busy_o(busy0)
  );

  slave_spi_word #(.WIDTH(16), .CPOL(1'b1), .CPHA(1'b1)) dut1 (
    .Clock(clk), .Reset(rst), .CS(cs), .SCK(sck1), .MOSI(mosi), .MISO(miso1),
    .DataToSend_i(dts1), .DataReceived_o(data1),
    .TransactionDone_o(done1), .Busy_o(busy1)
  );

  // Every completion pulse delivers one word into the per-instance queue.
  always @(negedge clk) begin
    if (done0 === 1'b1) rxq0.push_back({24'h0, data0});
    if (done1 === 1'b1) rxq1.push_back({16'h0, data1});
  end

  task automatic half();
    repeat (6) @(negedge clk);
  endtask

  // Master side of one word (or the first nbits of it); returns what was read on MISO.
  task automatic xfer(input int sel, input logic [31:0] mw, input int nbits,
                      input logic [31:0] tx_now, input logic [31:0] tx_next,
                      output logic [31:0] got);
    int w;
    logic b;
    w = (sel != 0) ? 16 : 8;
    got = 0;
    for (int i = 0; i < nbits; i++) begin
      b = mw[w-1-i];
      if (sel == 0) begin
        mosi = b;
        half();
        got = {got[30:0], miso0};
        sck0 = 1'b1;
        half();
        if (i == w - 1) dts0 = tx_next[7:0];
        sck0 = 1'b0;
      end else begin
        if (i == 0) dts1 = tx_now[15:0];
        sck1 = 1'b0;
        mosi = b;
        half();
        got = {got[30:0], miso1};
        sck1 = 1'b1;
        half();
      end
    end
  endtask

  // One CS-low frame of n back-to-back words; mw = master words, sw = words the slave must return.
  task automatic run_frame(input int sel, input int n, input logic [31:0] mw[4],
                           input logic [31:0] sw[4]);
    logic [31:0] mask, got, nxt, r;
    int w, qs;
    w = (sel != 0) ? 16 : 8;
    mask = (sel != 0) ? 32'hFFFF : 32'hFF;
    if (sel == 0) dts0 = sw[0][7:0];
    cs = 1'b0;
    for (int k = 0; k < n; k++) begin
      nxt = (k + 1 < n) ? sw[k+1] : $urandom;
      xfer(sel, mw[k], w, sw[k], nxt, got);
      checks++;
      if (got !== (sw[k] & mask)) begin
        errors++;
        $display("FAIL miso_word dut%0d word%0d: got %h expected %h", sel, k, got, sw[k] & mask);
      end
      qs = (sel != 0) ? rxq1.size() : rxq0.size();
      checks++;
      if (qs == 0) begin
        errors++;
        $display("FAIL rx_pulse dut%0d word%0d: got no pulse expected %h", sel, k, mw[k] & mask);
      end else begin
        r = (sel != 0) ? rxq1.pop_front() : rxq0.pop_front();
        if (r !== (mw[k] & mask)) begin
          errors++;
          $display("FAIL rx_word dut%0d word%0d: got %h expected %h", sel, k, r, mw[k] & mask);
        end
      end
      checks++;
      if (((sel != 0) ? busy1 : busy0) !== 1'b1) begin
        errors++;
        $display("FAIL busy_high dut%0d: got %b expected 1", sel, (sel != 0) ? busy1 : busy0);
      end
    end
    if (sel != 0) last_rx1 = mw[n-1] & mask;
    else          last_rx0 = mw[n-1] & mask;
    half();
    cs = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (((sel != 0) ? busy1 : busy0) !== 1'b0) begin
      errors++;
      $display("FAIL busy_low dut%0d: got %b expected 0", sel, (sel != 0) ? busy1 : busy0);
    end
    qs = (sel != 0) ? rxq1.size() : rxq0.size();
    checks++;
    if (qs != 0) begin
      errors++;
      $display("FAIL extra_pulses dut%0d: got %0d expected 0", sel, qs);
    end
    checks++;
    if (((sel != 0) ? miso1 : miso0) !== idle_miso) begin
      errors++;
      $display("FAIL miso_idle dut%0d: got %b expected %b", sel, (sel != 0) ? miso1 : miso0, idle_miso);
    end
    $display("frame dut%0d words=%0d last_rx=%h", sel, n, mw[n-1] & mask);
  endtask

  task automatic test_reset();
    rst = 1'b1; cs = 1'b1; mosi = 1'b0; sck0 = 1'b0; sck1 = 1'b1;
    dts0 = 8'h00; dts1 = 16'h0000;
    repeat (3) @(negedge clk);
    checks++;
    if (data0 !== 8'h00 || done0 !== 1'b0 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_dut0: got data=%h done=%b busy=%b expected 00 0 0", data0, done0, busy0);
    end
    checks++;
    if (data1 !== 16'h0000 || done1 !== 1'b0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_dut1: got data=%h done=%b busy=%b expected 0000 0 0", data1, done1, busy1);
    end
    checks++;
    if (miso0 !== idle_miso || miso1 !== idle_miso) begin
      errors++;
      $display("FAIL reset_miso: got %b/%b expected %b", miso0, miso1, idle_miso);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    $display("reset checked");
  endtask

  task automatic test_back_to_back();
    logic [31:0] mw[4], sw[4];
    mw[0] = 32'h01; mw[1] = 32'h03; mw[2] = 32'h07; mw[3] = 32'h0F;
    for (int i = 0; i < 4; i++) sw[i] = $urandom & 32'hFF;
    run_frame(0, 4, mw, sw);
  endtask

  task automatic test_mode0_first_bit();
    logic [31:0] mw[4], sw[4];
    dts0 = 8'hA5;
    cs = 1'b0;
    half();
    checks++;
    if (miso0 !== 1'b1) begin
      errors++;
      $display("FAIL first_bit: got %b expected 1", miso0);
    end
    cs = 1'b1;
    repeat (10) @(negedge clk);
    mw[0] = $urandom & 32'hFF; sw[0] = 32'hA5;
    for (int i = 1; i < 4; i++) begin mw[i] = 0; sw[i] = 0; end
    run_frame(0, 1, mw, sw);
  endtask

  task automatic test_mode3();
    logic [31:0] mw[4], sw[4];
    mw[0] = 32'h1234; sw[0] = 32'hBEEF;
    for (int i = 1; i < 4; i++) begin mw[i] = 0; sw[i] = 0; end
    run_frame(1, 1, mw, sw);
    checks++;
    if (data1 !== 16'h1234) begin
      errors++;
      $display("FAIL mode3_data: got %h expected 1234", data1);
    end
  endtask

  task automatic test_abort();
    logic [31:0] mw[4], sw[4], got;
    dts0 = $urandom;
    cs = 1'b0;
    xfer(0, $urandom, 5, 0, 0, got);
    half();
    cs = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (rxq0.size() != 0 || data0 !== last_rx0[7:0]) begin
      errors++;
      $display("FAIL abort_partial: got pulses=%0d data=%h expected 0 %h", rxq0.size(), data0, last_rx0[7:0]);
    end
    mw[0] = 32'h3C; sw[0] = $urandom & 32'hFF;
    for (int i = 1; i < 4; i++) begin mw[i] = 0; sw[i] = 0; end
    run_frame(0, 1, mw, sw);
    checks++;
    if (data0 !== 8'h3C) begin
      errors++;
      $display("FAIL abort_next: got %h expected 3c", data0);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] mw[4], sw[4], got;
    dts0 = $urandom;
    cs = 1'b0;
    xfer(0, $urandom, 4, 0, 0, got);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (data0 !== 8'h00 || done0 !== 1'b0 || busy0 !== 1'b0 || miso0 !== idle_miso) begin
      errors++;
      $display("FAIL reset_mid: got data=%h done=%b busy=%b miso=%b expected 00 0 0 %b",
               data0, done0, busy0, miso0, idle_miso);
    end
    checks++;
    if (data1 !== 16'h0000) begin
      errors++;
      $display("FAIL reset_mid_dut1: got %h expected 0000", data1);
    end
    @(negedge clk);
    rst = 1'b0;
    cs = 1'b1;
    sck0 = 1'b0;
    last_rx0 = 0;
    last_rx1 = 0;
    repeat (10) @(negedge clk);
    rxq0.delete();
    mw[0] = 32'h5A; sw[0] = $urandom & 32'hFF;
    for (int i = 1; i < 4; i++) begin mw[i] = 0; sw[i] = 0; end
    run_frame(0, 1, mw, sw);
  endtask

  task automatic test_random();
    logic [31:0] mw[4], sw[4];
    int sel, n;
    for (int it = 0; it < 8; it++) begin
      sel = $urandom_range(0, 1);
      n = $urandom_range(1, 4);
      for (int i = 0; i < 4; i++) begin
        mw[i] = $urandom & ((sel != 0) ? 32'hFFFF : 32'hFF);
        sw[i] = $urandom & ((sel != 0) ? 32'hFFFF : 32'hFF);
      end
      run_frame(sel, n, mw, sw);
    end
  endtask

  initial begin
`ifdef SLAVE_SPI_MISO_TRISTATE_EN
    idle_miso = 1'bz;
`else
    idle_miso = 1'b0;
`endif
    test_reset();
    test_back_to_back();
    test_mode0_first_bit();
    test_mode3();
    test_abort();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
